// File: rtl/eq2.sv
// Two-bit unsigned comparator with registered equality, rising-edge pulse and
// an optional saturating equality counter (compiled in when EQ2_STATS_EN is defined).
module eq2 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       j0,
  input  logic [1:0]       j1,
  input  logic             cnt_clr,
  output logic             aEqb,
  output logic             aGtb,
  output logic             aLtb,
  output logic             aEqb_q,
  output logic             eq_rise,
  output logic [CNT_W-1:0] eq_cnt
);

  logic eq_hi;
  logic eq_lo;
  logic aeqb_d;
  logic aeqb_q;
  logic rise_d;
  logic rise_q;

  // Bitwise compare: the high bit decides unless it ties, then the low bit decides.
  always_comb begin
    eq_hi = j0[1] ~^ j1[1];
    eq_lo = j0[0] ~^ j1[0];
    aEqb  = eq_hi & eq_lo;
    aGtb  = (j0[1] & ~j1[1]) | (eq_hi & j0[0] & ~j1[0]);
    aLtb  = (~j0[1] & j1[1]) | (eq_hi & ~j0[0] & j1[0]);
  end

  always_comb begin
    aeqb_d = aEqb;
    rise_d = aEqb & ~aeqb_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aeqb_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      aeqb_q <= aeqb_d;
      rise_q <= rise_d;
    end
  end

  assign aEqb_q  = aeqb_q;
  assign eq_rise = rise_q;

`ifdef EQ2_STATS_EN
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (aEqb && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign eq_cnt = cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign eq_cnt         = '0;
`endif

endmodule

// File: tb/tb_eq2.sv
// Self-checking bench for eq2: directed reset/compare/saturation steps plus a
// randomized phase, all checked against a behavioural model kept here.
module tb_eq2;

`ifdef EQ2_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk;
  logic       clk_run;
  logic       reset;
  logic [1:0] j0;
  logic [1:0] j1;
  logic       cnt_clr;

  logic       aEqb, aGtb, aLtb, aEqb_q, eq_rise;
  logic [7:0] eq_cnt;
  logic       aEqb2, aGtb2, aLtb2, aEqb_q2, eq_rise2;
  logic [1:0] eq_cnt2;

  int errors = 0;
  int checks = 0;

  bit m_prev;
  bit m_rise;
  int m_cnt8;
  int m_cnt2;

  eq2 #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .j0(j0), .j1(j1), .cnt_clr(cnt_clr),
    .aEqb(aEqb), .aGtb(aGtb), .aLtb(aLtb), .aEqb_q(aEqb_q),
    .eq_rise(eq_rise), .eq_cnt(eq_cnt)
  );

  eq2 #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .j0(j0), .j1(j1), .cnt_clr(cnt_clr),
    .aEqb(aEqb2), .aGtb(aGtb2), .aLtb(aLtb2), .aEqb_q(aEqb_q2),
    .eq_rise(eq_rise2), .eq_cnt(eq_cnt2)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  task automatic checkComb(input string tag);
    int a;
    int b;
    a = int'(j0);
    b = int'(j1);
    checkVal({tag, "_eq"}, 16'(aEqb), 16'(a == b));
    checkVal({tag, "_gt"}, 16'(aGtb), 16'(a > b));
    checkVal({tag, "_lt"}, 16'(aLtb), 16'(a < b));
    checkVal({tag, "_onehot"}, 16'(int'(aEqb) + int'(aGtb) + int'(aLtb)), 16'd1);
  endtask

  task automatic modelReset();
    m_prev = 1'b0;
    m_rise = 1'b0;
    m_cnt8 = 0;
    m_cnt2 = 0;
  endtask

  task automatic modelEdge();
    bit eq;
    eq     = (int'(j0) == int'(j1));
    m_rise = eq && !m_prev;
    m_prev = eq;
    if (STATS) begin
      if (cnt_clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end else if (eq) begin
        m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
        m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    checkComb(tag);
    checkVal({tag, "_eqq"}, 16'(aEqb_q), 16'(m_prev));
    checkVal({tag, "_rise"}, 16'(eq_rise), 16'(m_rise));
    checkVal({tag, "_cnt8"}, 16'(eq_cnt), 16'(m_cnt8));
    checkVal({tag, "_eqq2"}, 16'(aEqb_q2), 16'(m_prev));
    checkVal({tag, "_rise2"}, 16'(eq_rise2), 16'(m_rise));
    checkVal({tag, "_cnt2"}, 16'(eq_cnt2), 16'(m_cnt2));
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b, input logic clr, input string tag);
    j0      = a;
    j1      = b;
    cnt_clr = clr;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    clk     = 1'b0;
    clk_run = 1'b0;
    reset   = 1'b1;
    j0      = 2'd0;
    j1      = 2'd0;
    cnt_clr = 1'b0;
    modelReset();

    #10;
    checkOutput("reset");

    j0 = 2'b00; j1 = 2'b00; #10; checkComb("c00_00");
    j0 = 2'b00; j1 = 2'b01; #10; checkComb("c00_01");
    j0 = 2'b01; j1 = 2'b00; #10; checkComb("c01_00");
    j0 = 2'b01; j1 = 2'b01; #10; checkComb("c01_01");

    for (int p = 0; p < 16; p++) begin
      j0 = 2'(p >> 2);
      j1 = 2'(p & 3);
      #10;
      checkComb($sformatf("sweep%0d", p));
    end
    checkOutput("reset_held");

    j0 = 2'b10;
    j1 = 2'b10;
    clk_run = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(2'b10, 2'b10, 1'b0, "hold1");
    applyStimulus(2'b10, 2'b10, 1'b0, "hold2");
    applyStimulus(2'b10, 2'b10, 1'b0, "hold3");
    if (STATS) checkVal("hold3_cnt_is3", 16'(eq_cnt), 16'd3);
    applyStimulus(2'b10, 2'b10, 1'b0, "sat4");
    applyStimulus(2'b10, 2'b10, 1'b0, "sat5");
    if (STATS) checkVal("sat5_cnt2_is3", 16'(eq_cnt2), 16'd3);
    applyStimulus(2'b11, 2'b11, 1'b0, "sat6");
    applyStimulus(2'b11, 2'b11, 1'b1, "clr");
    checkVal("clr_cnt2_zero", 16'(eq_cnt2), 16'd0);
    applyStimulus(2'b01, 2'b10, 1'b0, "neq");
    applyStimulus(2'b00, 2'b00, 1'b0, "rise_again");

    for (int i = 0; i < 40; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 7) == 0), $sformatf("rnd%0d", i));
    end

    applyStimulus(2'b00, 2'b01, 1'b1, "pre_clr");
    applyStimulus(2'b10, 2'b10, 1'b0, "pre_eq1");
    applyStimulus(2'b10, 2'b10, 1'b0, "pre_eq2");
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("async_rst");
    j0 = 2'b11;
    j1 = 2'b01;
    #1;
    checkComb("async_rst_comb");
    @(posedge clk);
    #1;
    checkOutput("rst_edge");
    reset = 1'b0;
    applyStimulus(2'b01, 2'b01, 1'b0, "post_rst1");
    applyStimulus(2'b01, 2'b01, 1'b0, "post_rst2");

    clk_run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
